phy_lane_scheduler: RTL and testbench

Front-end controller for the PHY transmit path. Buffers the four 8-bit lane inputs (dataIn0..3/validIn0..3) in per-lane FIFOs. Sequences link bring-up (comma training, then active), then shares the single PHY byte channel between the four lanes with round-robin arbitration and PHY back-pressure. Sits between the lane sources and the PHY Tx parallel input, in the clk_4f domain.

---
 rtl/phy_lane_scheduler.sv | 203 ++++++++++++++++++++
 tb/tb_phy_lane_scheduler.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/phy_lane_scheduler.sv
// PHY transmit front-end: four per-lane byte FIFOs, link bring-up (comma training),
// and round-robin sharing of the single PHY byte channel under PHY back-pressure.
module phy_lane_scheduler #(
   parameter int         FIFO_DEPTH  = 4,
   parameter int         AFULL_TH    = 3,
   parameter int         INIT_CYCLES = 8,
   parameter logic [7:0] COMMA       = 8'hBC,
   parameter logic [7:0] IDLE_SYM    = 8'h7C
) (
   input  logic       clk_4f,
   input  logic       reset,
   input  logic       enable,
   input  logic [7:0] dataIn0,
   input  logic [7:0] dataIn1,
   input  logic [7:0] dataIn2,
   input  logic [7:0] dataIn3,
   input  logic       validIn0,
   input  logic       validIn1,
   input  logic       validIn2,
   input  logic       validIn3,
   input  logic       readyIn,
   output logic       almostFull0,
   output logic       almostFull1,
   output logic       almostFull2,
   output logic       almostFull3,
   output logic       overflow0,
   output logic       overflow1,
   output logic       overflow2,
   output logic       overflow3,
   output logic [7:0] dataOut,
   output logic       validOut,
   output logic [1:0] laneOut,
   output logic       linkActive,
   output logic [1:0] state
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam int IW = $clog2(INIT_CYCLES) + 1;

   typedef enum logic [1:0] {
      S_IDLE   = 2'b00,
      S_INIT   = 2'b01,
      S_ACTIVE = 2'b10
   } state_t;

   logic [7:0]    w_din [4];
   logic [3:0]    w_vin;
   logic [3:0]    w_push;
   logic [3:0]    w_full;
   logic [3:0]    w_nonempty;
   logic [3:0]    w_pop;

   logic [7:0]    r_mem [4][FIFO_DEPTH];
   logic [AW-1:0] r_wptr [4];
   logic [AW-1:0] r_rptr [4];
   logic [CW-1:0] r_cnt [4];
   logic [3:0]    r_ovf;

   state_t        r_state, w_state_nxt;
   logic [IW-1:0] r_initCnt, w_initCnt_nxt;
   logic [1:0]    r_last, w_last_nxt;
   logic [7:0]    r_dout, w_dout_nxt;
   logic          r_vout, w_vout_nxt;
   logic [1:0]    r_lane, w_lane_nxt;
   logic          r_link;

   logic          w_gnt_found;
   logic [1:0]    w_gnt_lane;
   logic [1:0]    w_cand;

   assign w_din[0] = dataIn0;
   assign w_din[1] = dataIn1;
   assign w_din[2] = dataIn2;
   assign w_din[3] = dataIn3;
   assign w_vin    = {validIn3, validIn2, validIn1, validIn0};

   always_comb begin
      for (int i = 0; i < 4; i++) begin
         w_full[i]     = (r_cnt[i] == CW'(FIFO_DEPTH));
         w_nonempty[i] = (r_cnt[i] != '0);
         w_push[i]     = w_vin[i] && !w_full[i];
      end
   end

   // Search starts one past the last grant, so lane r_last itself is checked last.
   always_comb begin
      w_gnt_found = 1'b0;
      w_gnt_lane  = r_last;
      w_cand      = r_last;
      for (int k = 1; k <= 4; k++) begin
         w_cand = r_last + 2'(k);
         if (!w_gnt_found && w_nonempty[w_cand]) begin
            w_gnt_found = 1'b1;
            w_gnt_lane  = w_cand;
         end
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_initCnt_nxt = r_initCnt;
      w_dout_nxt    = IDLE_SYM;
      w_vout_nxt    = 1'b0;
      w_lane_nxt    = r_lane;
      w_last_nxt    = r_last;
      w_pop         = 4'b0000;
      if (!enable) begin
         w_state_nxt   = S_IDLE;
         w_initCnt_nxt = '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               w_state_nxt   = S_INIT;
               w_initCnt_nxt = '0;
               w_dout_nxt    = COMMA;
            end
            S_INIT: begin
               if (r_initCnt == IW'(INIT_CYCLES - 1)) begin
                  w_state_nxt = S_ACTIVE;
               end else begin
                  w_initCnt_nxt = r_initCnt + IW'(1);
                  w_dout_nxt    = COMMA;
               end
            end
            S_ACTIVE: begin
               if (readyIn && w_gnt_found) begin
                  w_pop[w_gnt_lane] = 1'b1;
                  w_dout_nxt        = r_mem[w_gnt_lane][r_rptr[w_gnt_lane]];
                  w_vout_nxt        = 1'b1;
                  w_lane_nxt        = w_gnt_lane;
                  w_last_nxt        = w_gnt_lane;
               end
            end
            default: w_state_nxt = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_4f or negedge reset) begin
      if (!reset) begin
         r_state   <= S_IDLE;
         r_initCnt <= '0;
         r_last    <= 2'd3;
         r_dout    <= 8'h00;
         r_vout    <= 1'b0;
         r_lane    <= 2'd0;
         r_link    <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_initCnt <= w_initCnt_nxt;
         r_last    <= w_last_nxt;
         r_dout    <= w_dout_nxt;
         r_vout    <= w_vout_nxt;
         r_lane    <= w_lane_nxt;
         r_link    <= (w_state_nxt == S_ACTIVE);
      end
   end

   // A full lane drops the write even when it is popped in the same cycle.
   always_ff @(posedge clk_4f or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < 4; i++) begin
            r_wptr[i] <= '0;
            r_rptr[i] <= '0;
            r_cnt[i]  <= '0;
         end
         r_ovf <= 4'b0000;
      end else begin
         for (int i = 0; i < 4; i++) begin
            r_ovf[i] <= w_vin[i] && w_full[i];
            if (w_push[i]) r_wptr[i] <= r_wptr[i] + AW'(1);
            if (w_pop[i])  r_rptr[i] <= r_rptr[i] + AW'(1);
            case ({w_push[i], w_pop[i]})
               2'b10:   r_cnt[i] <= r_cnt[i] + CW'(1);
               2'b01:   r_cnt[i] <= r_cnt[i] - CW'(1);
               default: r_cnt[i] <= r_cnt[i];
            endcase
         end
      end
   end

   always_ff @(posedge clk_4f) begin
      for (int i = 0; i < 4; i++) begin
         if (w_push[i]) r_mem[i][r_wptr[i]] <= w_din[i];
      end
   end

   assign almostFull0 = (r_cnt[0] >= CW'(AFULL_TH));
   assign almostFull1 = (r_cnt[1] >= CW'(AFULL_TH));
   assign almostFull2 = (r_cnt[2] >= CW'(AFULL_TH));
   assign almostFull3 = (r_cnt[3] >= CW'(AFULL_TH));
   assign overflow0   = r_ovf[0];
   assign overflow1   = r_ovf[1];
   assign overflow2   = r_ovf[2];
   assign overflow3   = r_ovf[3];
   assign dataOut     = r_dout;
   assign validOut    = r_vout;
   assign laneOut     = r_lane;
   assign linkActive  = r_link;
   assign state       = r_state;

endmodule

// File: tb/tb_phy_lane_scheduler.sv
// Directed bench for phy_lane_scheduler: bring-up, latency, round-robin order,
// overflow, back-pressure, enable drop and asynchronous reset.
module tb_phy_lane_scheduler;

   logic       clk_4f = 1'b0;
   logic       reset = 1'b0;
   logic       enable = 1'b0;
   logic [7:0] dataIn0 = 8'h00, dataIn1 = 8'h00, dataIn2 = 8'h00, dataIn3 = 8'h00;
   logic       validIn0 = 1'b0, validIn1 = 1'b0, validIn2 = 1'b0, validIn3 = 1'b0;
   logic       readyIn = 1'b0;
   logic       almostFull0, almostFull1, almostFull2, almostFull3;
   logic       overflow0, overflow1, overflow2, overflow3;
   logic [7:0] dataOut;
   logic       validOut;
   logic [1:0] laneOut;
   logic       linkActive;
   logic [1:0] state;

   int n_checks = 0;
   int n_fail   = 0;

   phy_lane_scheduler dut (
      .clk_4f(clk_4f), .reset(reset), .enable(enable),
      .dataIn0(dataIn0), .dataIn1(dataIn1), .dataIn2(dataIn2), .dataIn3(dataIn3),
      .validIn0(validIn0), .validIn1(validIn1), .validIn2(validIn2), .validIn3(validIn3),
      .readyIn(readyIn),
      .almostFull0(almostFull0), .almostFull1(almostFull1),
      .almostFull2(almostFull2), .almostFull3(almostFull3),
      .overflow0(overflow0), .overflow1(overflow1),
      .overflow2(overflow2), .overflow3(overflow3),
      .dataOut(dataOut), .validOut(validOut), .laneOut(laneOut),
      .linkActive(linkActive), .state(state)
   );

   always #5 clk_4f = ~clk_4f;

   wire [3:0] w_af  = {almostFull3, almostFull2, almostFull1, almostFull0};
   wire [3:0] w_ovf = {overflow3, overflow2, overflow1, overflow0};

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_4f);
      #1;
   endtask

   task automatic expect_out(input string tag, input logic [7:0] d, input logic v, input logic [1:0] l);
      check_eq({tag, "_data"}, 32'(dataOut), 32'(d));
      check_eq({tag, "_valid"}, 32'(validOut), 32'(v));
      check_eq({tag, "_lane"}, 32'(laneOut), 32'(l));
   endtask

   task automatic bringup();
      for (int i = 0; i < 8; i++) begin
         tick();
         check_eq("init_state", 32'(state), 32'h1);
         check_eq("init_comma", 32'(dataOut), 32'hBC);
         check_eq("init_valid", 32'(validOut), 32'h0);
      end
      tick();
      check_eq("active_state", 32'(state), 32'h2);
      check_eq("active_idle_sym", 32'(dataOut), 32'h7C);
      check_eq("active_link", 32'(linkActive), 32'h1);
      check_eq("active_valid", 32'(validOut), 32'h0);
   endtask

   initial begin
      logic [3:0] af_exp;
      logic [7:0] tog_d [6];
      logic       tog_v [6];
      logic [1:0] tog_l [6];
      logic       tog_r [6];

      // Reset state
      tick();
      tick();
      check_eq("rst_state", 32'(state), 32'h0);
      check_eq("rst_data", 32'(dataOut), 32'h00);
      check_eq("rst_valid", 32'(validOut), 32'h0);
      check_eq("rst_lane", 32'(laneOut), 32'h0);
      check_eq("rst_link", 32'(linkActive), 32'h0);
      check_eq("rst_ovf", 32'(w_ovf), 32'h0);
      check_eq("rst_af", 32'(w_af), 32'h0);

      reset   = 1'b1;
      enable  = 1'b1;
      readyIn = 1'b1;
      bringup();

      // Fill every lane with 3 bytes under back-pressure, then drain round-robin
      readyIn = 1'b0;
      for (int j = 0; j < 3; j++) begin
         dataIn0 = 8'h00 + 8'(j); dataIn1 = 8'h10 + 8'(j);
         dataIn2 = 8'h20 + 8'(j); dataIn3 = 8'h30 + 8'(j);
         {validIn3, validIn2, validIn1, validIn0} = 4'hF;
         tick();
      end
      {validIn3, validIn2, validIn1, validIn0} = 4'h0;
      check_eq("fill_af", 32'(w_af), 32'hF);
      check_eq("fill_ovf", 32'(w_ovf), 32'h0);
      check_eq("fill_hold_valid", 32'(validOut), 32'h0);
      readyIn = 1'b1;
      for (int i = 0; i < 12; i++) begin
         tick();
         expect_out("rr", 8'((i % 4) * 16 + (i / 4)), 1'b1, 2'(i % 4));
         af_exp = 4'hF;
         af_exp = af_exp << (i + 1);
         check_eq("rr_af", 32'(w_af), 32'(af_exp));
      end
      tick();
      expect_out("rr_empty", 8'h7C, 1'b0, 2'd3);

      // Single-byte latency on lane 2
      dataIn2  = 8'h11;
      validIn2 = 1'b1;
      tick();
      validIn2 = 1'b0;
      check_eq("lat_k_valid", 32'(validOut), 32'h0);
      tick();
      expect_out("lat_k1", 8'h11, 1'b1, 2'd2);
      tick();
      expect_out("lat_after", 8'h7C, 1'b0, 2'd2);

      // Lane 1 overflow: 5 writes into a 4-deep FIFO
      readyIn  = 1'b0;
      validIn1 = 1'b1;
      for (int i = 0; i < 5; i++) begin
         dataIn1 = 8'hA0 + 8'(i);
         tick();
         check_eq("ovf_pulse", 32'(overflow1), (i == 4) ? 32'h1 : 32'h0);
      end
      validIn1 = 1'b0;
      tick();
      check_eq("ovf_single", 32'(overflow1), 32'h0);
      check_eq("ovf_af1", 32'(almostFull1), 32'h1);
      expect_out("ovf_hold", 8'h7C, 1'b0, 2'd2);
      readyIn = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         expect_out("ovf_drain", 8'hA0 + 8'(i), 1'b1, 2'd1);
      end
      tick();
      check_eq("ovf_no_fifth", 32'(validOut), 32'h0);

      // readyIn toggling mid-stream
      readyIn = 1'b0;
      for (int j = 0; j < 3; j++) begin
         dataIn0  = 8'hC0 + 8'(j);
         dataIn3  = 8'hD0 + 8'(j);
         validIn0 = 1'b1;
         validIn3 = (j < 2);
         tick();
      end
      validIn0 = 1'b0;
      validIn3 = 1'b0;
      tog_r = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
      tog_d = '{8'hD0, 8'hC0, 8'h7C, 8'hD1, 8'hC1, 8'hC2};
      tog_v = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
      tog_l = '{2'd3, 2'd0, 2'd0, 2'd3, 2'd0, 2'd0};
      for (int i = 0; i < 6; i++) begin
         readyIn = tog_r[i];
         tick();
         expect_out("toggle", tog_d[i], tog_v[i], tog_l[i]);
      end
      tick();
      check_eq("toggle_empty", 32'(validOut), 32'h0);

      // Drop enable mid-stream, keep writing, re-enable
      readyIn = 1'b0;
      for (int j = 0; j < 3; j++) begin
         dataIn2  = 8'hE0 + 8'(j);
         validIn2 = 1'b1;
         tick();
      end
      validIn2 = 1'b0;
      readyIn  = 1'b1;
      tick();
      expect_out("en_first", 8'hE0, 1'b1, 2'd2);
      enable   = 1'b0;
      dataIn0  = 8'hF0;
      validIn0 = 1'b1;
      tick();
      validIn0 = 1'b0;
      check_eq("en_off_state", 32'(state), 32'h0);
      check_eq("en_off_link", 32'(linkActive), 32'h0);
      expect_out("en_off", 8'h7C, 1'b0, 2'd2);
      tick();
      check_eq("en_off_stay", 32'(state), 32'h0);
      enable = 1'b1;
      bringup();
      tick();
      expect_out("en_resume0", 8'hF0, 1'b1, 2'd0);
      tick();
      expect_out("en_resume1", 8'hE1, 1'b1, 2'd2);
      tick();
      expect_out("en_resume2", 8'hE2, 1'b1, 2'd2);
      tick();
      check_eq("en_resume_empty", 32'(validOut), 32'h0);

      // Asynchronous reset mid-burst
      readyIn = 1'b0;
      for (int j = 0; j < 4; j++) begin
         dataIn0  = 8'h50 + 8'(j);
         validIn0 = 1'b1;
         tick();
      end
      validIn0 = 1'b0;
      readyIn  = 1'b1;
      tick();
      expect_out("burst", 8'h50, 1'b1, 2'd0);
      check_eq("burst_af0", 32'(almostFull0), 32'h1);
      #2;
      reset = 1'b0;
      #1;
      check_eq("arst_state", 32'(state), 32'h0);
      check_eq("arst_link", 32'(linkActive), 32'h0);
      check_eq("arst_af", 32'(w_af), 32'h0);
      expect_out("arst", 8'h00, 1'b0, 2'd0);
      tick();
      reset = 1'b1;
      bringup();
      tick();
      expect_out("arst_fifo_empty", 8'h7C, 1'b0, 2'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

endmodule
